// File: rtl/scfetch.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// registers each fetched word with its PC into a valid/ready slot for decode.
module scfetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        redir_valid,
    input  logic [1:0]  redir_kind,
    input  logic [31:0] redir_base,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_reg,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JUMP   = 2'b01;
    localparam logic [1:0] KIND_JR     = 2'b10;

    function automatic logic [31:0] branch_target(input logic [31:0] b4,
                                                  input logic [15:0] imm);
        branch_target = b4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] b4,
                                                input logic [25:0] imm);
        jump_target = {b4[31:28], imm, 2'b00};
    endfunction

    logic [31:0] pc_q, pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_valid_q, out_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redir_eff_s;
    logic [31:0] base4_s;
    logic [31:0] target_s;

    // Redirect target selection; reserved kind is treated as no redirect.
    always_comb begin
        base4_s     = redir_base + 32'd4;
        redir_eff_s = 1'b0;
        target_s    = pc_q;
        case (redir_kind)
            KIND_BRANCH: begin
                redir_eff_s = redir_valid;
                target_s    = branch_target(base4_s, redir_imm[15:0]);
            end
            KIND_JUMP: begin
                redir_eff_s = redir_valid;
                target_s    = jump_target(base4_s, redir_imm);
            end
            KIND_JR: begin
                redir_eff_s = redir_valid;
                target_s    = {redir_reg[31:2], 2'b00};
            end
            default: begin
                redir_eff_s = 1'b0;
                target_s    = pc_q;
            end
        endcase
    end

    // Next-state: redirect flushes the slot, otherwise load when the slot frees.
    always_comb begin
        pc_d          = pc_q;
        out_inst_d    = out_inst_q;
        out_pc_d      = out_pc_q;
        out_valid_d   = out_valid_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q;

        // A slot flushed by a redirect in the same cycle still counts as accepted.
        if (out_valid_q && out_ready) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end

        if (redir_eff_s) begin
            pc_d        = target_s;
            out_valid_d = 1'b0;
            if ((redir_kind == KIND_JR) && (redir_reg[1:0] != 2'b00)) begin
                misalign_d = 1'b1;
            end else begin
                misalign_d = misalign_q;
            end
        end else if (!out_valid_q || out_ready) begin
            out_inst_d  = imem_inst;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
        end else begin
            pc_d        = pc_q;
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            out_inst_q    <= 32'h0000_0000;
            out_pc_q      <= 32'h0000_0000;
            out_valid_q   <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            out_inst_q    <= out_inst_d;
            out_pc_q      <= out_pc_d;
            out_valid_q   <= out_valid_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign out_inst    = out_inst_q;
    assign out_pc      = out_pc_q;
    assign out_valid   = out_valid_q;
    assign misalign    = misalign_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_scfetch.sv
// Directed bench for scfetch: sequential fetch, stall, redirects, misalign and
// PC wrap, checked against hand-computed values.
module tb_scfetch;

    logic        clk;
    logic        rst;
    logic        out_ready;
    logic        redir_valid;
    logic [1:0]  redir_kind;
    logic [31:0] redir_base;
    logic [25:0] redir_imm;
    logic [31:0] redir_reg;

    logic [31:0] imem_addr, imem_inst, out_inst, out_pc, fetch_count;
    logic        out_valid, misalign;

    logic [31:0] imem_addr2, imem_inst2, out_inst2, out_pc2, fetch_count2;
    logic        out_valid2, misalign2;

    logic [31:0] rom [0:31];

    int checks;
    int failures;

    assign imem_inst  = rom[imem_addr[6:2]];
    assign imem_inst2 = rom[imem_addr2[6:2]];

    scfetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_inst(imem_inst),
        .out_inst(out_inst), .out_pc(out_pc), .out_valid(out_valid),
        .out_ready(out_ready),
        .redir_valid(redir_valid), .redir_kind(redir_kind),
        .redir_base(redir_base), .redir_imm(redir_imm), .redir_reg(redir_reg),
        .misalign(misalign), .fetch_count(fetch_count)
    );

    scfetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr2), .imem_inst(imem_inst2),
        .out_inst(out_inst2), .out_pc(out_pc2), .out_valid(out_valid2),
        .out_ready(1'b1),
        .redir_valid(1'b0), .redir_kind(2'b00),
        .redir_base(32'h0000_0000), .redir_imm(26'h000_0000),
        .redir_reg(32'h0000_0000),
        .misalign(misalign2), .fetch_count(fetch_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_redir(input logic v, input logic [1:0] k,
                             input logic [31:0] b, input logic [25:0] i,
                             input logic [31:0] r);
        redir_valid = v;
        redir_kind  = k;
        redir_base  = b;
        redir_imm   = i;
        redir_reg   = r;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 + 32'(i);
        rom[0]  = 32'h3c01_0000;
        rom[1]  = 32'h3424_0050;
        rom[2]  = 32'h2005_0004;
        rom[24] = 32'h0000_4020;

        // Reset with a redirect pending: reset must win.
        rst       = 1'b1;
        out_ready = 1'b0;
        set_redir(1'b1, 2'b01, 32'h0000_000C, 26'h000_0018, 32'h0);
        step();
        step();
        check_val("rst_pc",        imem_addr,   32'h0000_0000);
        check_val("rst_valid",     {31'd0, out_valid}, 32'd0);
        check_val("rst_out_pc",    out_pc,      32'h0000_0000);
        check_val("rst_out_inst",  out_inst,    32'h0000_0000);
        check_val("rst_count",     fetch_count, 32'd0);
        check_val("rst_misalign",  {31'd0, misalign}, 32'd0);
        check_val("wrap_rst_pc",   imem_addr2,  32'hFFFF_FFFC);

        rst       = 1'b0;
        out_ready = 1'b1;
        set_redir(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        step();
        check_val("seq0_pc",    out_pc,   32'h0000_0000);
        check_val("seq0_inst",  out_inst, 32'h3c01_0000);
        check_val("seq0_valid", {31'd0, out_valid}, 32'd1);
        check_val("wrap_out_pc",  out_pc2,    32'hFFFF_FFFC);
        check_val("wrap_next_pc", imem_addr2, 32'h0000_0000);
        step();
        check_val("seq1_pc",   out_pc,   32'h0000_0004);
        check_val("seq1_inst", out_inst, 32'h3424_0050);

        // Stall three cycles holding the 0x04 slot.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_pc",    out_pc,    32'h0000_0004);
            check_val("stall_inst",  out_inst,  32'h3424_0050);
            check_val("stall_addr",  imem_addr, 32'h0000_0008);
            check_val("stall_count", fetch_count, 32'd1);
        end
        out_ready = 1'b1;
        step();
        check_val("seq2_pc",    out_pc,      32'h0000_0008);
        check_val("seq2_inst",  out_inst,    32'h2005_0004);
        check_val("seq2_count", fetch_count, 32'd2);

        // Jump: flush counts the accepted slot, out_pc unchanged.
        set_redir(1'b1, 2'b01, 32'h0000_000C, 26'h000_0018, 32'h0);
        step();
        check_val("jump_addr",   imem_addr,   32'h0000_0060);
        check_val("jump_valid",  {31'd0, out_valid}, 32'd0);
        check_val("jump_outpc",  out_pc,      32'h0000_0008);
        check_val("jump_count",  fetch_count, 32'd3);
        set_redir(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        step();
        check_val("jump_tgt_pc",   out_pc,   32'h0000_0060);
        check_val("jump_tgt_inst", out_inst, 32'h0000_4020);
        check_val("jump_tgt_valid", {31'd0, out_valid}, 32'd1);

        set_redir(1'b1, 2'b00, 32'h0000_0074, 26'h000_FFFB, 32'h0);
        step();
        check_val("bbranch_addr",  imem_addr,   32'h0000_0064);
        check_val("bbranch_count", fetch_count, 32'd4);
        set_redir(1'b1, 2'b00, 32'h0000_0040, 26'h000_0001, 32'h0);
        step();
        check_val("fbranch_addr",  imem_addr,   32'h0000_0048);
        check_val("fbranch_count", fetch_count, 32'd4);

        set_redir(1'b1, 2'b10, 32'h0, 26'h0, 32'h0000_0010);
        step();
        check_val("jr_addr",     imem_addr, 32'h0000_0010);
        check_val("jr_misalign", {31'd0, misalign}, 32'd0);
        set_redir(1'b1, 2'b10, 32'h0, 26'h0, 32'h0000_0013);
        step();
        check_val("jrm_addr",     imem_addr, 32'h0000_0010);
        check_val("jrm_misalign", {31'd0, misalign}, 32'd1);
        set_redir(1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        step();
        check_val("jr_tgt_pc",   out_pc,   32'h0000_0010);
        check_val("jr_tgt_inst", out_inst, 32'hA000_0004);
        check_val("jr_sticky",   {31'd0, misalign}, 32'd1);

        // Redirect while stalled still flushes.
        out_ready = 1'b0;
        set_redir(1'b1, 2'b00, 32'h0000_0000, 26'h000_0002, 32'h0);
        step();
        check_val("stallred_addr",  imem_addr,   32'h0000_000C);
        check_val("stallred_valid", {31'd0, out_valid}, 32'd0);
        check_val("stallred_outpc", out_pc,      32'h0000_0010);
        check_val("stallred_count", fetch_count, 32'd4);

        // Reserved kind behaves as no redirect.
        out_ready = 1'b1;
        set_redir(1'b1, 2'b11, 32'h0000_0100, 26'h000_0040, 32'h0000_0200);
        step();
        check_val("rsv_pc",    out_pc,    32'h0000_000C);
        check_val("rsv_inst",  out_inst,  32'hA000_0003);
        check_val("rsv_addr",  imem_addr, 32'h0000_0010);
        check_val("rsv_valid", {31'd0, out_valid}, 32'd1);

        // Reset clears sticky misalign and overrides a pending jump.
        rst = 1'b1;
        set_redir(1'b1, 2'b01, 32'h0000_000C, 26'h000_0018, 32'h0);
        step();
        check_val("rst2_addr",     imem_addr, 32'h0000_0000);
        check_val("rst2_misalign", {31'd0, misalign}, 32'd0);
        check_val("rst2_valid",    {31'd0, out_valid}, 32'd0);
        check_val("rst2_count",    fetch_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scfetch.md
Name: scfetch

Overview:
Instruction-fetch stage upstream of the 32-word instruction ROM. It owns the PC, drives the ROM word address and registers the returned instruction with its PC into a valid/ready output slot for decode. It computes next-PC targets for sequential flow, branch, jump and jr, and supports decode stalls and redirect flushes.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_addr  out  32  instruction memory byte address (= pc register, combinational)
imem_inst  in  32  instruction returned combinationally for imem_addr
out_inst  out  32  registered instruction to decode
out_pc  out  32  byte address of out_inst
out_valid  out  1  out_inst/out_pc hold a valid instruction
out_ready  in  1  decode accepts the slot this cycle
redir_valid  in  1  redirect request this cycle
redir_kind  in  2  00 branch, 01 jump, 10 jr, 11 reserved (ignored)
redir_base  in  32  PC of the redirecting instruction
redir_imm  in  26  branch uses [15:0]; jump uses all 26 bits
redir_reg  in  32  jr target register value
misalign  out  1  sticky: a jr target had nonzero bits [1:0]
fetch_count  out  32  number of accepted transfers (out_valid & out_ready)

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC, out_valid<=0, out_inst<=0, out_pc<=0, misalign<=0, fetch_count<=0. Reset overrides all other inputs, including mid-stall or mid-redirect.
- imem_addr = pc at all times.
- Effective redirect: redir_valid=1 and redir_kind!=11. kind=11 with redir_valid=1 is treated exactly like redir_valid=0.
- Target computation, all 32-bit modulo 2^32, using b4 = redir_base+4:
  - branch: b4 + (sign_extend(redir_imm[15:0]) << 2)
  - jump: {b4[31:28], redir_imm[25:0], 2'b00}
  - jr: {redir_reg[31:2], 2'b00}; if redir_reg[1:0]!=0, set misalign<=1. It stays set until reset.
- Priority each cycle: reset > effective redirect > load > hold.
  - Redirect: pc<=target and out_valid<=0 (flush), regardless of out_ready. out_inst and out_pc are unchanged.
  - Load, when (!out_valid | out_ready): out_inst<=imem_inst, out_pc<=pc, out_valid<=1, pc<=pc+4.
  - Hold, when out_valid & !out_ready: pc, out_inst, out_pc and out_valid are all unchanged.
- fetch_count increments on every edge where out_valid & out_ready, including the redirect cycle, because the flushed slot is still counted as accepted. It wraps from 0xFFFFFFFF to 0.
- Latency:
  - Sequential flow delivers one instruction per cycle when out_ready is held at 1.
  - After reset deasserts at edge E0, the first instruction is valid after edge E0+1.
  - After a redirect at edge N, the target instruction is valid after edge N+1.
- PC wrap: pc=0xFFFFFFFC loads, then pc becomes 0x00000000.
- No state is X after reset. Outputs change only on clk edges, except imem_addr, which follows pc.

Test Plan:
- Reset then out_ready=1 for 3 cycles, ROM as loaded (0x3c010000, 0x34240050, 0x20050004, ...) -> out (pc, inst) sequence: (0x00, 0x3c010000), (0x04, 0x34240050), (0x08, 0x20050004). fetch_count=2 after the third load edge.
- Stall: out_ready=0 for 3 cycles while holding (0x04, 0x34240050) -> out_pc, out_inst and imem_addr=0x08 stable. On the first edge with out_ready=1, expect (0x08, 0x20050004).
- Jump: redir kind=01, base=0x0C, imm=0x0000018 -> next pc=0x60, out_valid=0 for one cycle, then (0x60, 0x00004020).
- Backward branch: kind=00, base=0x74, imm[15:0]=0xFFFB -> pc=0x64. Forward branch: base=0x40, imm=0x0001 -> pc=0x48.
- jr: redir_reg=0x10 -> pc=0x10, misalign=0. Then redir_reg=0x13 -> pc=0x10, misalign=1, and misalign stays 1 until rst.
- Corner cases:
  - RESET_PC=0xFFFFFFFC -> second imem_addr is 0x00000000.
  - Redirect during a stall (out_ready=0) -> flush with out_valid=0.
  - kind=11 -> normal sequential fetch.
  - rst asserted with redir_valid=1 -> pc=RESET_PC.
